// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus.
// master: the MEM/WB stage and ID-stage readers. They drive the writeback
//         operands and the read addresses, and they receive read data,
//         the writeback value, the effective write enable and the counters.
// slave : wb_regfile.
interface wb_regfile_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] wb_dataALU;
  logic [XLEN-1:0] wb_datamem;
  logic            wb_memtoreg;
  logic            wb_RegWr;
  logic            wb_MemRd;
  logic [2:0]      wb_Load_sel;
  logic [4:0]      wb_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_we;
  logic [31:0]     commit_cnt;
  logic [31:0]     load_cnt;

  modport master (
    output wb_dataALU, wb_datamem, wb_memtoreg, wb_RegWr, wb_MemRd,
           wb_Load_sel, wb_rd, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_wdata, wb_we, commit_cnt, load_cnt
  );

  modport slave (
    input  wb_dataALU, wb_datamem, wb_memtoreg, wb_RegWr, wb_MemRd,
           wb_Load_sel, wb_rd, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_wdata, wb_we, commit_cnt, load_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 integer register file.
// Ports:
//   clk - posedge clock for the register array and the counters.
//   rst - synchronous, active-high reset. It clears x1..x31 and both
//         counters, and it takes priority over a coincident write.
//   bus - wb_regfile_if.slave. It carries the MEM/WB operands, two ID read
//         ports with same-cycle bypass, the writeback value for forwarding,
//         the effective write enable and the commit/load counters.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int NRD = 2;

  logic [XLEN-1:0]           rf [NREG];
  logic [XLEN-1:0]           ld_data;
  logic [XLEN-1:0]           wdata;
  logic                      we;
  logic [31:0]               commit_q;
  logic [31:0]               load_q;
  logic [NRD-1:0][4:0]       raddr;
  logic [NRD-1:0][XLEN-1:0]  rdata;

  // Load extraction. off[0] is not used for halfwords, so a misaligned
  // halfword returns the containing aligned halfword.
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off = bus.wb_dataALU[1:0];

  always_comb begin
    ld_byte = bus.wb_datamem[7:0];
    case (off)
      2'd0: ld_byte = bus.wb_datamem[7:0];
      2'd1: ld_byte = bus.wb_datamem[15:8];
      2'd2: ld_byte = bus.wb_datamem[23:16];
      2'd3: ld_byte = bus.wb_datamem[31:24];
      default: ld_byte = bus.wb_datamem[7:0];
    endcase
    ld_half = off[1] ? bus.wb_datamem[31:16] : bus.wb_datamem[15:0];
  end

  // Undefined funct3 codes (011, 110, 111) fall back to a full-word load.
  always_comb begin
    ld_data = bus.wb_datamem;
    case (bus.wb_Load_sel)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.wb_datamem;
    endcase
  end

  assign wdata        = bus.wb_memtoreg ? ld_data : bus.wb_dataALU;
  assign we           = bus.wb_RegWr && (bus.wb_rd != 5'd0);
  assign bus.wb_wdata = wdata;
  assign bus.wb_we    = we;

  // Register array. Entry 0 is only ever cleared, and reads of x0 are
  // forced to zero, so x0 stays hardwired.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (we) begin
      rf[bus.wb_rd] <= wdata;
    end
  end

  // Read ports. The write-through bypass lets ID see a value that is
  // committed on this same edge.
  assign raddr = {bus.rs2_addr, bus.rs1_addr};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdata[p] = (raddr[p] == 5'd0)                 ? '0    :
                      (we && (raddr[p] == bus.wb_rd))    ? wdata :
                                                           rf[raddr[p]];
  end

  assign bus.rs1_data = rdata[0];
  assign bus.rs2_data = rdata[1];

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q <= '0;
      load_q   <= '0;
    end else if (we) begin
      commit_q <= commit_q + 32'd1;
      if (bus.wb_MemRd && bus.wb_memtoreg) load_q <= load_q + 32'd1;
    end
  end

  assign bus.commit_cnt = commit_q;
  assign bus.load_cnt   = load_q;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  logic clk;
  logic rst;

  wb_regfile_if bus();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference state. Reads, writes and counters are modelled with plain
  // arrays and integers.
  logic [31:0] mdl_reg [32];
  logic [31:0] mdl_commit;
  logic [31:0] mdl_load;

  typedef struct {
    logic [2:0]  sel;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Compute the load value arithmetically from funct3 and the byte offset.
  function automatic logic [31:0] ref_load(input logic [2:0] sel, input logic [31:0] alu,
                                           input logic [31:0] mem);
    int unsigned o;
    logic [31:0] b;
    logic [31:0] h;
    o = alu % 4;
    b = (mem >> (8 * o)) & 32'hFF;
    h = (mem >> (16 * (o / 2))) & 32'hFFFF;
    case (sel)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000)  ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return mem;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata();
    return bus.wb_memtoreg ? ref_load(bus.wb_Load_sel, bus.wb_dataALU, bus.wb_datamem)
                           : bus.wb_dataALU;
  endfunction

  function automatic logic ref_we();
    return bus.wb_RegWr && (bus.wb_rd != 0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (ref_we() && a == bus.wb_rd) return ref_wdata();
    return mdl_reg[a];
  endfunction

  task automatic drive(input logic regwr, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic m2r, input logic memrd,
                       input logic [2:0] sel);
    bus.wb_RegWr    = regwr;
    bus.wb_rd       = rd;
    bus.wb_dataALU  = alu;
    bus.wb_datamem  = mem;
    bus.wb_memtoreg = m2r;
    bus.wb_MemRd    = memrd;
    bus.wb_Load_sel = sel;
  endtask

  task automatic chk_comb(input string tag);
    #1;
    chk({tag, " rs1"},   bus.rs1_data, ref_read(bus.rs1_addr));
    chk({tag, " rs2"},   bus.rs2_data, ref_read(bus.rs2_addr));
    chk({tag, " wdata"}, bus.wb_wdata, ref_wdata());
    chk({tag, " we"},    {31'd0, bus.wb_we}, {31'd0, ref_we()});
  endtask

  // Advance one posedge, update the model, and return to the negedge,
  // where the next inputs are driven.
  task automatic tick();
    logic        w;
    logic [31:0] d;
    w = ref_we();
    d = ref_wdata();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_reg[i] = 32'd0;
      mdl_commit = 32'd0;
      mdl_load   = 32'd0;
    end else if (w) begin
      mdl_reg[bus.wb_rd] = d;
      mdl_commit = mdl_commit + 32'd1;
      if (bus.wb_MemRd && bus.wb_memtoreg) mdl_load = mdl_load + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    #1;
    chk({tag, " commit_cnt"}, bus.commit_cnt, mdl_commit);
    chk({tag, " load_cnt"},   bus.load_cnt,   mdl_load);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) mdl_reg[i] = 32'hX;
    mdl_commit = 32'hX;
    mdl_load   = 32'hX;

    ld_tab[0] = '{3'b000, 2'd0, 32'hFFFF_FF82};
    ld_tab[1] = '{3'b100, 2'd0, 32'h0000_0082};
    ld_tab[2] = '{3'b000, 2'd1, 32'h0000_007F};
    ld_tab[3] = '{3'b001, 2'd2, 32'hFFFF_80F1};
    ld_tab[4] = '{3'b101, 2'd3, 32'h0000_80F1};
    ld_tab[5] = '{3'b010, 2'd1, 32'h80F1_7F82};
    ld_tab[6] = '{3'b111, 2'd0, 32'h80F1_7F82};

    // Reset asserted together with a write to x5; the write must be dropped.
    rst = 1'b1;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    drive(1'b1, 5'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 3'b010);
    @(negedge clk);
    #1 chk("rst we follows input", {31'd0, bus.wb_we}, 32'd1);
    chk("rst wdata follows input", bus.wb_wdata, 32'h1234_5678);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 3'b010);
    chk_cnt("after rst");
    chk("commit_cnt zero after rst", bus.commit_cnt, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("rst rs1 x%0d", i), bus.rs1_data, 32'd0);
      chk($sformatf("rst rs2 x%0d", 31 - i), bus.rs2_data, 32'd0);
    end

    // ALU write to x3: visible through the bypass, then from the array.
    @(negedge clk);
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd4;
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("alu bypass x3", bus.rs1_data, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("alu held x3", bus.rs1_data, 32'hDEAD_BEEF);
    chk("alu commit_cnt", bus.commit_cnt, 32'd1);

    // Load extraction, table driven.
    for (int i = 0; i < 7; i++) begin
      bus.rs1_addr = 5'(10 + i);
      drive(1'b1, 5'(10 + i), {30'h0400_0000, ld_tab[i].off}, 32'h80F1_7F82, 1'b1, 1'b1,
            ld_tab[i].sel);
      #1;
      chk($sformatf("load[%0d] wdata", i), bus.wb_wdata, ld_tab[i].exp);
      chk($sformatf("load[%0d] bypass", i), bus.rs1_data, ld_tab[i].exp);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("load_cnt after 7 loads", bus.load_cnt, 32'd7);
    chk("commit_cnt after loads", bus.commit_cnt, 32'd8);

    // MemRd without memtoreg writes the ALU result and is not a load commit.
    drive(1'b1, 5'd9, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b000);
    #1 chk("memrd alu wdata", bus.wb_wdata, 32'h0000_1234);
    tick();
    chk_cnt("memrd no m2r");

    // Write to x0 is discarded.
    bus.rs1_addr = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("x0 we", {31'd0, bus.wb_we}, 32'd0);
    chk("x0 read", bus.rs1_data, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("x0 commit_cnt unchanged", bus.commit_cnt, 32'd9);

    // Both ports read the register being written; x8 keeps its old value.
    drive(1'b1, 5'd8, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, 3'b010);
    tick();
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd7;
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("dual rs1 x7", bus.rs1_data, 32'hA5A5_A5A5);
    chk("dual rs2 x7", bus.rs2_data, 32'hA5A5_A5A5);
    bus.rs2_addr = 5'd8;
    #1 chk("rs2 old x8", bus.rs2_data, 32'h0BAD_F00D);
    tick();

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 59) == 0);
      drive(1'($urandom), rd, $urandom, $urandom, 1'($urandom), 1'($urandom),
            3'($urandom));
      bus.rs1_addr = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      bus.rs2_addr = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
      chk_comb($sformatf("rand[%0d]", n));
      tick();
      chk_cnt($sformatf("rand[%0d]", n));
    end
    rst = 1'b0;

    // Counter wrap: preload both counters with all-ones, then do one load commit.
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    force dut.commit_q = 32'hFFFF_FFFF;
    force dut.load_q   = 32'hFFFF_FFFF;
    #1;
    release dut.commit_q;
    release dut.load_q;
    mdl_commit = 32'hFFFF_FFFF;
    mdl_load   = 32'hFFFF_FFFF;
    #1 chk("preload commit_cnt", bus.commit_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 5'd20, 32'h0, 32'h1111_2222, 1'b1, 1'b1, 3'b010);
    tick();
    #1 chk("wrap commit_cnt", bus.commit_cnt, 32'd0);
    chk("wrap load_cnt", bus.load_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
